// File: rtl/waymask_victim_selector.sv
// Waymask-enforcing victim selector.
// Per-set round-robin scan, one way per cycle, for a way enabled in the active mask.
// Returns a one-hot victim under a valid/ack handshake.
// Mask updates are staged and applied only while idle.
// Optional per-way eviction counters are built when VICTIM_STAT_EN is defined.
module waymask_victim_selector #(
  parameter int unsigned CACHE_ASSOCIATIVITY = 16,
  parameter int unsigned SET_INDEX_WIDTH     = 6,
  parameter int unsigned COUNTER_WIDTH       = 32
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic [CACHE_ASSOCIATIVITY-1:0]               waymask_in,
  input  logic                                         waymask_update_in,
  output logic [CACHE_ASSOCIATIVITY-1:0]               active_waymask_out,
  input  logic                                         replace_valid_in,
  input  logic [SET_INDEX_WIDTH-1:0]                   replace_set_in,
  output logic                                         replace_ready_out,
  output logic                                         victim_valid_out,
  output logic [CACHE_ASSOCIATIVITY-1:0]               victim_way_out,
  input  logic                                         victim_ack_in,
  output logic [CACHE_ASSOCIATIVITY*COUNTER_WIDTH-1:0] evict_counter_flatted_out
);

  localparam int unsigned WayW    = (CACHE_ASSOCIATIVITY > 1) ? $clog2(CACHE_ASSOCIATIVITY) : 1;
  localparam int unsigned NumSets = 1 << SET_INDEX_WIDTH;

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e                           state_q, state_d;
  logic [SET_INDEX_WIDTH-1:0]       set_q, set_d;
  logic [WayW-1:0]                  cand_q, cand_d;
  logic [WayW-1:0]                  victim_q, victim_d;
  logic                             valid_q, valid_d;
  logic [CACHE_ASSOCIATIVITY-1:0]   active_q, active_d;
  logic [CACHE_ASSOCIATIVITY-1:0]   pend_q, pend_d;
  logic                             pend_valid_q, pend_valid_d;
  logic [WayW-1:0]                  ptr_q [NumSets];
  logic                             ptr_we;

  // Round-robin successor, wrapping at the last way.
  function automatic logic [WayW-1:0] next_way(input logic [WayW-1:0] w);
    if (w == WayW'(CACHE_ASSOCIATIVITY - 1)) return '0;
    return w + 1'b1;
  endfunction

  // Next-state: mask staging, scan FSM and handshake.
  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    cand_d       = cand_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    active_d     = active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    ptr_we       = 1'b0;

    // An all-zero mask would never terminate the scan, so it means "all ways".
    if (state_q == StIdle && pend_valid_q) begin
      active_d     = (pend_q == '0) ? '1 : pend_q;
      pend_valid_d = 1'b0;
    end
    if (waymask_update_in) begin
      pend_d       = waymask_in;
      pend_valid_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (replace_valid_in) begin
          set_d   = replace_set_in;
          cand_d  = ptr_q[replace_set_in];
          state_d = StScan;
        end
      end
      StScan: begin
        if (active_q[cand_q]) begin
          victim_d = cand_q;
          state_d  = StDone;
        end else begin
          cand_d = next_way(cand_q);
        end
      end
      StDone: begin
        // Valid rises one cycle after entering DONE; acks before that are ignored.
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (victim_ack_in) begin
          valid_d = 1'b0;
          ptr_we  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q      <= StIdle;
      set_q        <= '0;
      cand_q       <= '0;
      victim_q     <= '0;
      valid_q      <= 1'b0;
      active_q     <= '1;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      for (int i = 0; i < int'(NumSets); i++) ptr_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      cand_q       <= cand_d;
      victim_q     <= victim_d;
      valid_q      <= valid_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      if (ptr_we) ptr_q[set_q] <= next_way(victim_q);
    end
  end

  assign active_waymask_out = active_q;
  assign replace_ready_out  = (state_q == StIdle) && !reset_in;
  assign victim_valid_out   = valid_q;
  assign victim_way_out     = valid_q ? ({{(CACHE_ASSOCIATIVITY-1){1'b0}}, 1'b1} << victim_q) : '0;

`ifdef VICTIM_STAT_EN
  logic [COUNTER_WIDTH-1:0] cnt_q [CACHE_ASSOCIATIVITY];

  // Saturating per-way eviction counters, bumped on each acked victim.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < int'(CACHE_ASSOCIATIVITY); i++) cnt_q[i] <= '0;
    end else if (valid_q && victim_ack_in && (cnt_q[victim_q] != '1)) begin
      cnt_q[victim_q] <= cnt_q[victim_q] + 1'b1;
    end
  end

  for (genvar g = 0; g < int'(CACHE_ASSOCIATIVITY); g++) begin : g_flat
    assign evict_counter_flatted_out[g*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[g];
  end
`else
  assign evict_counter_flatted_out = '0;
`endif

endmodule

// File: doc/waymask_victim_selector.md
Name: waymask_victim_selector

Overview:
- Consumer of the way-partition suggestion produced by the hit-profiling block. It takes the suggested waymask and enforces it in the replacement path.
- Accepts per-set replacement requests and scans ways round-robin from a per-set pointer, one way per cycle, until it finds a way enabled in the active mask. It returns that way as a one-hot victim under a valid/ack handshake.
- Mask updates are staged and applied only when no replacement is in flight.

Parameters:
- CACHE_ASSOCIATIVITY, 16, number of ways; mask and victim width.
- SET_INDEX_WIDTH, 6, set index width; 2**SET_INDEX_WIDTH round-robin pointers.
- COUNTER_WIDTH, 32, eviction statistic counter width (optional feature only).

Ports:
- clk_in  input  1  clock.
- reset_in  input  1  synchronous reset, active-high.
- waymask_in  input  CACHE_ASSOCIATIVITY  suggested waymask; bit i = way i allowed.
- waymask_update_in  input  1  one-cycle strobe; captures waymask_in into the pending register.
- active_waymask_out  output  CACHE_ASSOCIATIVITY  mask currently enforced.
- replace_valid_in  input  1  replacement request.
- replace_set_in  input  SET_INDEX_WIDTH  set index of the request.
- replace_ready_out  output  1  high only in IDLE.
- victim_valid_out  output  1  victim available.
- victim_way_out  output  CACHE_ASSOCIATIVITY  one-hot victim; zero when victim_valid_out=0.
- victim_ack_in  input  1  victim consumed.
- evict_counter_flatted_out  output  CACHE_ASSOCIATIVITY*COUNTER_WIDTH  per-way eviction counts; way i at [i*COUNTER_WIDTH +: COUNTER_WIDTH].

Behaviour:
- One clock (clk_in); reset_in is synchronous, active-high.
- Reset values:
  - state=IDLE; all pointers=0; active mask=all ones; pending_valid=0.
  - victim_valid_out=0; victim_way_out=0; counters=0.
  - replace_ready_out=0 during the reset cycle, then 1.
- FSM states:
  - IDLE: replace_ready_out=1. On replace_valid_in, latch the set and load cand=ptr[set], then go to SCAN.
  - SCAN: each cycle test active_mask[cand].
    - Set → latch victim=cand and go to DONE.
    - Clear → cand=(cand+1) mod CACHE_ASSOCIATIVITY.
    - At most CACHE_ASSOCIATIVITY SCAN cycles.
  - DONE: victim_valid_out=1, victim_way_out=onehot(victim), both held stable until victim_ack_in. On ack, ptr[set]=(victim+1) mod CACHE_ASSOCIATIVITY, victim_valid_out drops next cycle, go to IDLE.
- Latency: request accepted at edge T. If the victim is k ways past ptr[set] (k=0..A-1), victim_valid_out rises at T+k+2.
- Ack while victim_valid_out=0 is ignored. Request held high in DONE is not accepted until IDLE.
- Mask staging:
  - waymask_update_in loads the pending register and sets pending_valid in any state; a later update overwrites an earlier one (latest wins).
  - At any edge with state=IDLE and pending_valid=1: active mask <= pending, pending_valid <= 0.
  - Active mask is frozen during SCAN and DONE.
  - Update in the same cycle as request acceptance: the request uses the old mask; the new mask applies at the next IDLE.
- Zero-mask rule: a pending mask of all zeros is applied as all ones, so SCAN always terminates.
- Pointer rule: only the acked set's pointer changes; other sets are untouched. Pointer wraps A-1 → 0.
- Reset mid-operation: returns to IDLE immediately, drops victim_valid_out, clears pointers and pending, restores the all-ones mask.

Optional Feature:
- Macro VICTIM_STAT_EN.
- Defined: per-way eviction counters increment on each acked victim (victim_valid_out & victim_ack_in) and saturate at all ones. Reset clears them. Output is the flattened counters.
- Undefined: no counters are built; evict_counter_flatted_out is tied to 0.

Test Plan:
- Reset, then request set 3 with mask 16'hFFFF → victim_way_out=16'h0001 at T+2. Ack sets ptr[3]=1; second request to set 3 → 16'h0002.
- waymask 16'h8000 applied, request set 0 with ptr=0 → victim_valid_out at T+17, victim_way_out=16'h8000. After ack, ptr wraps to 0.
- Update to 16'h00F0 in the same cycle as request acceptance, with active mask FFFF → victim 16'h0001. Next request → 16'h0010.
- waymask 16'h0000 applied → active_waymask_out=16'hFFFF. Two updates while in DONE (16'h0003 then 16'h0C00) → 16'h0C00 applied after ack.
- victim_ack_in held low 10 cycles → victim_valid_out and victim_way_out stable, replace_ready_out=0. Reset asserted in DONE → victim_valid_out=0 and ready=1 the cycle after reset.
- With VICTIM_STAT_EN, 5 acked victims on way 2 → count field 2 = 5, other fields = 0. Without the macro the output is all zeros.
